// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter slice.
// Counter width default, nominal divider period, FSM states.
package period_meter_pkg;

  localparam int DEF_CNT_W      = 18;
  localparam int NOMINAL_PERIOD = 200002;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/period_meter_if.sv
// Result handshake bundle: valid/ready plus the measured fields.
// master drives the result, slave consumes it.
interface period_meter_if
  import period_meter_pkg::*;
#(
  parameter int W = DEF_CNT_W
) ();

  logic         meas_valid;
  logic         meas_ready;
  logic [W-1:0] period;
  logic [W-1:0] high_time;

  modport master (
    output meas_valid,
    output period,
    output high_time,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  period,
    input  high_time,
    output meas_ready
  );

endinterface

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer plus edge register for slow async inputs.
// Outputs the synchronized level and one-cycle rise/fall strobes.
module sync_edge_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an async square wave in clk_in
// cycles; flags stalled input (timeout) and dropped results (overrun).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_PERIOD = 250000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clear_flags,
  period_meter_if.master   m,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic level;
  logic rise;
  logic fall;

  sync_edge_detect u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hl_q, hl_d;
  logic             hf_q, hf_d;
  logic             res_v_q, res_v_d;
  logic [CNT_W-1:0] res_p_q, res_p_d;
  logic [CNT_W-1:0] res_h_q, res_h_d;
  logic             tmo_evt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hl_d    = hl_q;
    hf_d    = hf_q;
    res_v_d = 1'b0;
    res_p_d = res_p_q;
    res_h_d = res_h_q;
    tmo_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        hf_d  = 1'b0;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
        end
      end
      MEASURE: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + ONE;
        if (rise) begin
          res_v_d = 1'b1;
          res_p_d = cnt_q;
          res_h_d = hf_q ? hl_q : cnt_q;
          cnt_d   = ONE;
          hf_d    = 1'b0;
        end else if (cnt_q >= MAXV) begin
          // next cycle would be MAX_PERIOD+1 with no rise
          tmo_evt = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          hf_d    = 1'b0;
        end else if (fall && !hf_q) begin
          hl_d = cnt_q;
          hf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hl_q    <= '0;
      hf_q    <= 1'b0;
      res_v_q <= 1'b0;
      res_p_q <= '0;
      res_h_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hl_q    <= hl_d;
      hf_q    <= hf_d;
      res_v_q <= res_v_d;
      res_p_q <= res_p_d;
      res_h_q <= res_h_d;
    end
  end

  logic             vld_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] hi_q;
  logic             tmo_q;
  logic             ovr_q;
  logic             load;
  logic             drop;
  logic             vld_d;

  assign drop  = res_v_q & vld_q & ~m.meas_ready;
  assign load  = res_v_q & ~drop;
  assign vld_d = load | (vld_q & ~m.meas_ready);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      per_q <= '0;
      hi_q  <= '0;
      tmo_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (load) begin
        per_q <= res_p_q;
        hi_q  <= res_h_q;
      end
      tmo_q <= tmo_evt | (tmo_q & ~clear_flags);
      ovr_q <= drop | (ovr_q & ~clear_flags);
    end
  end

  assign m.meas_valid = vld_q;
  assign m.period     = per_q;
  assign m.high_time  = hi_q;
  assign timeout      = tmo_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a reduced MAX_PERIOD.
// Each scenario task checks its own hand-computed results.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int CNT_W = 18;
  localparam int MAXP  = 1000;

  logic clk_in = 1'b0;
  logic reset = 1'b0;
  logic sig_in = 1'b0;
  logic clear_flags = 1'b0;
  logic timeout;
  logic overrun;

  period_meter_if #(.W(CNT_W)) mif ();

  period_meter #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sig_in      (sig_in),
    .clear_flags (clear_flags),
    .m           (mif.master),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  always #5 clk_in = ~clk_in;

  int vec = 0;
  int bad = 0;
  int vcyc = 0;
  logic [CNT_W-1:0] qp[$];
  logic [CNT_W-1:0] qh[$];

  always @(posedge clk_in) begin
    if (reset && mif.meas_valid) begin
      vcyc++;
      if (mif.meas_ready) begin
        qp.push_back(mif.period);
        qh.push_back(mif.high_time);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wave(input int h, input int l);
    sig_in = 1'b1;
    cyc(h);
    sig_in = 1'b0;
    cyc(l);
  endtask

  task automatic restart();
    @(negedge clk_in);
    sig_in = 1'b0;
    clear_flags = 1'b0;
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    qp.delete();
    qh.delete();
    vcyc = 0;
  endtask

  task automatic test_reset();
    mif.meas_ready = 1'b1;
    reset = 1'b0;
    cyc(3);
    vec++;
    if (mif.meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got %b want 0", mif.meas_valid);
    end
    vec++;
    if (mif.period !== '0 || mif.high_time !== '0) begin
      bad++;
      $display("FAIL reset_data got %0d/%0d want 0/0",
               mif.period, mif.high_time);
    end
    vec++;
    if (timeout !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got %b%b want 00", timeout, overrun);
    end
    reset = 1'b1;
    cyc(2);
  endtask

  task automatic test_basic();
    restart();
    mif.meas_ready = 1'b1;
    repeat (4) wave(50, 50);
    sig_in = 1'b1;
    cyc(10);
    vec++;
    if (qp.size() !== 4) begin
      bad++;
      $display("FAIL basic_count got %0d want 4", qp.size());
    end
    for (int i = 0; i < qp.size(); i++) begin
      vec++;
      if (qp[i] !== 100 || qh[i] !== 50) begin
        bad++;
        $display("FAIL basic_res%0d got %0d/%0d want 100/50",
                 i, qp[i], qh[i]);
      end
    end
    vec++;
    if (vcyc !== 4) begin
      bad++;
      $display("FAIL basic_pulse got %0d valid cycles want 4", vcyc);
    end
    vec++;
    if (timeout !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL basic_flags got %b%b want 00", timeout, overrun);
    end
  endtask

  task automatic test_latency();
    int k;
    restart();
    mif.meas_ready = 1'b1;
    wave(30, 70);
    sig_in = 1'b1;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_in);
      #1;
      if (k == 0 && mif.meas_valid) k = i;
    end
    vec++;
    if (k !== 4) begin
      bad++;
      $display("FAIL latency got %0d cycles want 4", k);
    end
    vec++;
    if (qp.size() !== 1) begin
      bad++;
      $display("FAIL duty_count got %0d want 1", qp.size());
    end else if (qp[0] !== 100 || qh[0] !== 30) begin
      bad++;
      $display("FAIL duty_res got %0d/%0d want 100/30", qp[0], qh[0]);
    end
  endtask

  task automatic test_backpressure();
    restart();
    mif.meas_ready = 1'b0;
    repeat (3) wave(50, 50);
    sig_in = 1'b1;
    cyc(10);
    vec++;
    if (mif.meas_valid !== 1'b1 || mif.period !== 100) begin
      bad++;
      $display("FAIL bp_hold got v=%b p=%0d want v=1 p=100",
               mif.meas_valid, mif.period);
    end
    vec++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_overrun got %b want 1", overrun);
    end
    mif.meas_ready = 1'b1;
    cyc(1);
    mif.meas_ready = 1'b0;
    cyc(1);
    vec++;
    if (mif.meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got %b want 0", mif.meas_valid);
    end
    vec++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_sticky got %b want 1", overrun);
    end
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    cyc(1);
    vec++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp_clear got %b want 0", overrun);
    end
    mif.meas_ready = 1'b1;
  endtask

  task automatic test_timeout();
    restart();
    mif.meas_ready = 1'b1;
    wave(10, 990);
    sig_in = 1'b1;
    cyc(10);
    sig_in = 1'b0;
    cyc(1100);
    vec++;
    if (qp.size() !== 1) begin
      bad++;
      $display("FAIL tmo_accept_count got %0d want 1", qp.size());
    end else if (qp[0] !== 1000 || qh[0] !== 10) begin
      bad++;
      $display("FAIL tmo_accept got %0d/%0d want 1000/10", qp[0], qh[0]);
    end
    vec++;
    if (timeout !== 1'b1) begin
      bad++;
      $display("FAIL tmo_flag got %b want 1", timeout);
    end
    vec++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL tmo_state got %0d want IDLE", dut.state_q);
    end
    vec++;
    if (vcyc !== 1) begin
      bad++;
      $display("FAIL tmo_noresult got %0d valid cycles want 1", vcyc);
    end
    wave(10, 90);
    vec++;
    if (qp.size() !== 1) begin
      bad++;
      $display("FAIL tmo_first_rise got %0d results want 1", qp.size());
    end
    sig_in = 1'b1;
    cyc(10);
    vec++;
    if (qp.size() !== 2) begin
      bad++;
      $display("FAIL tmo_second_count got %0d want 2", qp.size());
    end else if (qp[1] !== 100 || qh[1] !== 10) begin
      bad++;
      $display("FAIL tmo_second got %0d/%0d want 100/10", qp[1], qh[1]);
    end
    vec++;
    if (timeout !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky got %b want 1", timeout);
    end
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    cyc(1);
    vec++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear got %b want 0", timeout);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    mif.meas_ready = 1'b0;
    wave(50, 50);
    sig_in = 1'b1;
    cyc(10);
    sig_in = 1'b0;
    cyc(20);
    vec++;
    if (mif.meas_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got %b want 1", mif.meas_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    vec++;
    if (mif.meas_valid !== 1'b0 || mif.period !== '0 ||
        mif.high_time !== '0 || timeout !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got v=%b p=%0d h=%0d t=%b o=%b want 0",
               mif.meas_valid, mif.period, mif.high_time,
               timeout, overrun);
    end
    cyc(2);
    reset = 1'b1;
    mif.meas_ready = 1'b1;
    cyc(2);
    qp.delete();
    qh.delete();
    vcyc = 0;
    wave(50, 50);
    vec++;
    if (vcyc !== 0) begin
      bad++;
      $display("FAIL rstmid_first got %0d valid cycles want 0", vcyc);
    end
    sig_in = 1'b1;
    cyc(10);
    vec++;
    if (qp.size() !== 1) begin
      bad++;
      $display("FAIL rstmid_second_count got %0d want 1", qp.size());
    end else if (qp[0] !== 100 || qh[0] !== 50) begin
      bad++;
      $display("FAIL rstmid_second got %0d/%0d want 100/50", qp[0], qh[0]);
    end
  endtask

  task automatic test_divider_scaled();
    restart();
    mif.meas_ready = 1'b1;
    repeat (3) wave(499, 499);
    sig_in = 1'b1;
    cyc(10);
    vec++;
    if (qp.size() !== 3) begin
      bad++;
      $display("FAIL div_count got %0d want 3", qp.size());
    end
    for (int i = 0; i < qp.size(); i++) begin
      vec++;
      if (qp[i] !== 998 || qh[i] !== 499) begin
        bad++;
        $display("FAIL div_res%0d got %0d/%0d want 998/499",
                 i, qp[i], qh[i]);
      end
    end
  endtask

  initial begin
    mif.meas_ready = 1'b1;
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_divider_scaled();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
